// File: rtl/atm_pkg.sv
// Shared encodings for the ATM account controller: opcodes, FSM states and status codes.
// The optional lockout feature is selected with the ATM_LOCKOUT_EN macro in the RTL files.
package atm_pkg;

    typedef logic [2:0] atm_code_t;

    localparam atm_code_t OP_BALANCE  = 3'd3;
    localparam atm_code_t OP_WITHDRAW = 3'd4;
    localparam atm_code_t OP_DEPOSIT  = 3'd5;
    localparam atm_code_t OP_CHG_PIN  = 3'd6;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ACC  = 3'd1;
    localparam logic [2:0] ST_PIN  = 3'd2;
    localparam logic [2:0] ST_EXEC = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    localparam atm_code_t STS_OK       = 3'd0;
    localparam atm_code_t STS_NO_ACCT  = 3'd1;
    localparam atm_code_t STS_BAD_PIN  = 3'd2;
    localparam atm_code_t STS_INSUF    = 3'd3;
    localparam atm_code_t STS_SAME_PIN = 3'd4;
    localparam atm_code_t STS_LOCKED   = 3'd5;
    localparam atm_code_t STS_BAD_OP   = 3'd6;
    localparam atm_code_t STS_OVERFLOW = 3'd7;

endpackage

// File: rtl/atm_acct_store.sv
// Account storage: PIN and balance arrays with one combinational read port and one write port.
// With ATM_LOCKOUT_EN defined it also holds per-account wrong-PIN counters, cleared by rst.
module atm_acct_store
    import atm_pkg::*;
#(
    parameter int NUM_ACCTS = 10,
    parameter int ACC_W     = 4,
    parameter int PIN_W     = 14,
    parameter int BAL_W     = 14,
    parameter int TRY_W     = 2
) (
    input  logic             clk,
    input  logic [ACC_W-1:0] rd_idx,
    output logic [PIN_W-1:0] rd_pin,
    output logic [BAL_W-1:0] rd_bal,
    input  logic             wr_data_en,
    input  logic [ACC_W-1:0] wr_idx,
    input  logic [PIN_W-1:0] wr_pin,
    input  logic [BAL_W-1:0] wr_bal
`ifdef ATM_LOCKOUT_EN
    ,
    input  logic             rst,
    output logic [TRY_W-1:0] rd_try,
    input  logic             wr_try_en,
    input  logic [TRY_W-1:0] wr_try
`endif
);

    logic [PIN_W-1:0] pin_mem [NUM_ACCTS];
    logic [BAL_W-1:0] bal_mem [NUM_ACCTS];
    logic             rd_hit;
    logic             wr_hit;

    assign rd_hit = {1'b0, rd_idx} < (ACC_W+1)'(NUM_ACCTS);
    assign wr_hit = {1'b0, wr_idx} < (ACC_W+1)'(NUM_ACCTS);
    assign rd_pin = rd_hit ? pin_mem[rd_idx] : '0;
    assign rd_bal = rd_hit ? bal_mem[rd_idx] : '0;

    // Pins and balances have no reset: they survive rst by design.
    always_ff @(posedge clk) begin
        if (wr_data_en && wr_hit) begin
            pin_mem[wr_idx] <= wr_pin;
            bal_mem[wr_idx] <= wr_bal;
        end
    end

`ifdef ATM_LOCKOUT_EN
    logic [TRY_W-1:0] try_mem [NUM_ACCTS];

    assign rd_try = rd_hit ? try_mem[rd_idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACCTS; i++) try_mem[i] <= '0;
        end else if (wr_try_en && wr_hit) begin
            try_mem[wr_idx] <= wr_try;
        end
    end
`endif

endmodule

// File: rtl/atm_bank.sv
// ATM account controller: a five-state request FSM in front of a small account store.
// Define ATM_LOCKOUT_EN to lock an account after MAX_TRIES consecutive wrong PINs.
module atm_bank
    import atm_pkg::*;
#(
    parameter int NUM_ACCTS = 10,
    parameter int ACC_W     = 4,
    parameter int PIN_W     = 14,
    parameter int BAL_W     = 14,
    parameter int MAX_TRIES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       op,
    input  logic [ACC_W-1:0] acc_num,
    input  logic [PIN_W-1:0] pin,
    input  logic [PIN_W-1:0] new_pin,
    input  logic [BAL_W-1:0] amount,
    input  logic             language,
    input  logic             init_we,
    input  logic [ACC_W-1:0] init_idx,
    input  logic [PIN_W-1:0] init_pin,
    input  logic [BAL_W-1:0] init_bal,
    output logic             rsp_valid,
    output logic             success,
    output logic [2:0]       status,
    output logic [BAL_W-1:0] balance,
    output logic             lang_out,
    output logic [2:0]       state
);
    // state | meaning
    // IDLE  | waiting for a request; init writes allowed
    // ACC   | account range check, lock check
    // PIN   | PIN compare, wrong-PIN counter update
    // EXEC  | run opcode; storage written on the way out
    // RESP  | rsp_valid high for one cycle

    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    logic [2:0]       op_q;
    logic [ACC_W-1:0] acc_q;
    logic [PIN_W-1:0] pin_q;
    logic [PIN_W-1:0] new_pin_q;
    logic [BAL_W-1:0] amt_q;
    logic             lang_q;

    logic [ACC_W-1:0] acct_idx;
    logic [PIN_W-1:0] rd_pin;
    logic [BAL_W-1:0] rd_bal;
    logic             acct_ok;
    logic             pin_bad;
    logic             locked;
    logic             init_hit;

    logic [BAL_W:0]   dep_sum;
    atm_code_t        exec_sts;
    logic [BAL_W-1:0] exec_bal;
    logic [PIN_W-1:0] exec_pin;
    logic             exec_wr;

    logic [2:0]       state_nx;
    logic             rsp_load;
    atm_code_t        rsp_sts;
    logic [BAL_W-1:0] rsp_bal;

    logic             wr_data_en;
    logic [ACC_W-1:0] wr_idx;
    logic [PIN_W-1:0] wr_pin;
    logic [BAL_W-1:0] wr_bal;

    assign req_ready = (state == ST_IDLE) && !init_we;
    assign rsp_valid = (state == ST_RESP);
    assign acct_idx  = acc_q - ACC_W'(1);
    assign acct_ok   = (acc_q != '0) && ({1'b0, acc_q} <= (ACC_W+1)'(NUM_ACCTS));
    assign pin_bad   = (rd_pin != pin_q);
    assign init_hit  = (state == ST_IDLE) && init_we && ({1'b0, init_idx} < (ACC_W+1)'(NUM_ACCTS));
    assign dep_sum   = {1'b0, rd_bal} + {1'b0, amt_q};

    always_comb begin
        exec_sts = STS_OK;
        exec_bal = rd_bal;
        exec_pin = rd_pin;
        exec_wr  = 1'b0;
        case (op_q)
            OP_BALANCE: exec_sts = STS_OK;
            OP_WITHDRAW: begin
                if (amt_q > rd_bal) exec_sts = STS_INSUF;
                else begin
                    exec_bal = rd_bal - amt_q;
                    exec_wr  = 1'b1;
                end
            end
            OP_DEPOSIT: begin
                if (dep_sum[BAL_W]) exec_sts = STS_OVERFLOW;
                else begin
                    exec_bal = dep_sum[BAL_W-1:0];
                    exec_wr  = 1'b1;
                end
            end
            OP_CHG_PIN: begin
                if (new_pin_q == rd_pin) exec_sts = STS_SAME_PIN;
                else begin
                    exec_pin = new_pin_q;
                    exec_wr  = 1'b1;
                end
            end
            default: exec_sts = STS_BAD_OP;
        endcase
    end

    always_comb begin
        state_nx = state;
        rsp_load = 1'b0;
        rsp_sts  = STS_OK;
        rsp_bal  = '0;
        case (state)
            ST_IDLE: if (req_valid && req_ready) state_nx = ST_ACC;
            ST_ACC: begin
                if (!acct_ok || locked) begin
                    state_nx = ST_RESP;
                    rsp_load = 1'b1;
                    rsp_sts  = !acct_ok ? STS_NO_ACCT : STS_LOCKED;
                end else begin
                    state_nx = ST_PIN;
                end
            end
            ST_PIN: begin
                if (pin_bad) begin
                    state_nx = ST_RESP;
                    rsp_load = 1'b1;
                    rsp_sts  = STS_BAD_PIN;
                end else begin
                    state_nx = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_nx = ST_RESP;
                rsp_load = 1'b1;
                rsp_sts  = exec_sts;
                rsp_bal  = exec_bal;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            success  <= 1'b0;
            status   <= STS_OK;
            balance  <= '0;
            lang_out <= 1'b0;
        end else begin
            state <= state_nx;
            if (rsp_load) begin
                success  <= (rsp_sts == STS_OK);
                status   <= rsp_sts;
                balance  <= rsp_bal;
                lang_out <= lang_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            op_q      <= op;
            acc_q     <= acc_num;
            pin_q     <= pin;
            new_pin_q <= new_pin;
            amt_q     <= amount;
            lang_q    <= language;
        end
    end

    // Init writes only happen in IDLE and request writes only on EXEC exit, so they never collide.
    assign wr_data_en = !rst && (init_hit || ((state == ST_EXEC) && exec_wr));
    assign wr_idx     = (state == ST_IDLE) ? init_idx : acct_idx;
    assign wr_pin     = (state == ST_IDLE) ? init_pin : exec_pin;
    assign wr_bal     = (state == ST_IDLE) ? init_bal : exec_bal;

`ifdef ATM_LOCKOUT_EN
    logic [TRY_W-1:0] rd_try;
    logic [TRY_W-1:0] wr_try;
    logic             wr_try_en;

    assign locked    = (rd_try == TRY_W'(MAX_TRIES));
    assign wr_try_en = !rst && (init_hit || (state == ST_PIN));
    assign wr_try    = ((state == ST_PIN) && pin_bad) ?
                       (locked ? rd_try : rd_try + TRY_W'(1)) : '0;
`else
    assign locked = 1'b0;
`endif

    atm_acct_store #(
        .NUM_ACCTS (NUM_ACCTS),
        .ACC_W     (ACC_W),
        .PIN_W     (PIN_W),
        .BAL_W     (BAL_W),
        .TRY_W     (TRY_W)
    ) u_store (
        .clk        (clk),
        .rd_idx     (acct_idx),
        .rd_pin     (rd_pin),
        .rd_bal     (rd_bal),
        .wr_data_en (wr_data_en),
        .wr_idx     (wr_idx),
        .wr_pin     (wr_pin),
        .wr_bal     (wr_bal)
`ifdef ATM_LOCKOUT_EN
        ,
        .rst        (rst),
        .rd_try     (rd_try),
        .wr_try_en  (wr_try_en),
        .wr_try     (wr_try)
`endif
    );

endmodule
